// File: rtl/iot_shout_pkg.sv
// Shared definitions for the shout pulse-burst line: receiver FSM states and
// default widths, so the generator and the listener agree on the format.
package iot_shout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STUCK = 2'd3
  } shout_state_e;

  localparam int SHOUT_SYNC_STAGES = 2;
  localparam int SHOUT_PULSE_W     = 5;
  localparam int SHOUT_PAUSE_W     = 10;
  localparam int SHOUT_MAX_PULSE   = 20;

endpackage

// File: rtl/iot_sync.sv
// Multi-flop synchroniser for a single asynchronous input. Clears to 0 on reset.
module iot_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/iot_listen.sv
// Shout line receiver: measures each high pulse and the low pause that follows,
// hands (pulse, pause) pairs to the host over a valid/ack register, and keeps
// sticky stuck/overrun flags plus a count of accepted measurements.
module iot_listen
  import iot_shout_pkg::*;
#(
  parameter int SYNC_STAGES = SHOUT_SYNC_STAGES,
  parameter int PULSE_W     = SHOUT_PULSE_W,
  parameter int PAUSE_W     = SHOUT_PAUSE_W,
  parameter int MAX_PULSE   = SHOUT_MAX_PULSE
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               enable,
  input  logic               shout_in,
  input  logic               meas_ack,
  input  logic               flag_clr,
  output logic [PULSE_W-1:0] pulse_len,
  output logic [PAUSE_W-1:0] pause_len,
  output logic               meas_valid,
  output logic               stuck,
  output logic               overrun,
  output logic [15:0]        burst_cnt
);

  localparam logic [PULSE_W-1:0] L_HMAX = PULSE_W'(MAX_PULSE);
  localparam logic [PULSE_W-1:0] L_HONE = PULSE_W'(1);
  localparam logic [PAUSE_W-1:0] L_LONE = PAUSE_W'(1);
  localparam logic [PAUSE_W-1:0] L_LSAT = {PAUSE_W{1'b1}};

  logic w_shout_s;
  logic r_shout_d;
  logic w_rise;
  logic w_fall;

  shout_state_e       r_state, w_state_nxt;
  logic [PULSE_W-1:0] r_hcnt, w_hcnt_nxt;
  logic [PULSE_W-1:0] r_plen, w_plen_nxt;
  logic [PAUSE_W-1:0] r_lcnt, w_lcnt_nxt;
  logic               w_capture;
  logic               w_stuck_set;

  logic [PULSE_W-1:0] r_pulse_len;
  logic [PAUSE_W-1:0] r_pause_len;
  logic               r_meas_valid;
  logic               r_stuck;
  logic               r_overrun;
  logic [15:0]        r_burst_cnt;

  iot_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (clk_in),
    .i_rst_n (reset),
    .i_async (shout_in),
    .o_sync  (w_shout_s)
  );

  // One-cycle delayed copy of the synchronised line for edge detection.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_shout_d <= 1'b0;
    end else begin
      r_shout_d <= w_shout_s;
    end
  end

  assign w_rise = w_shout_s & ~r_shout_d;
  assign w_fall = ~w_shout_s & r_shout_d;

  // Next-state and counter logic; a rise while in LOW closes a measurement.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_lcnt_nxt  = r_lcnt;
    w_plen_nxt  = r_plen;
    w_capture   = 1'b0;
    w_stuck_set = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_hcnt_nxt  = '0;
      w_lcnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_HIGH;
            w_hcnt_nxt  = L_HONE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            w_state_nxt = ST_LOW;
            w_plen_nxt  = r_hcnt;
            w_lcnt_nxt  = L_LONE;
          end else if (r_hcnt >= (L_HMAX - L_HONE)) begin
            // The count about to reach MAX_PULSE means the line is stuck.
            w_state_nxt = ST_STUCK;
            w_hcnt_nxt  = L_HMAX;
            w_stuck_set = 1'b1;
          end else begin
            w_hcnt_nxt  = r_hcnt + L_HONE;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_HIGH;
            w_hcnt_nxt  = L_HONE;
          end else if (r_lcnt != L_LSAT) begin
            w_lcnt_nxt  = r_lcnt + L_LONE;
          end else begin
            w_lcnt_nxt  = L_LSAT;
          end
        end
        ST_STUCK: begin
          if (w_fall) begin
            w_state_nxt = ST_IDLE;
            w_hcnt_nxt  = '0;
          end else begin
            w_state_nxt = ST_STUCK;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_hcnt_nxt  = '0;
          w_lcnt_nxt  = '0;
        end
      endcase
    end
  end

  // FSM state and measurement counters.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_lcnt  <= '0;
      r_plen  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_lcnt  <= w_lcnt_nxt;
      r_plen  <= w_plen_nxt;
    end
  end

  // Host holding register: accept a capture when free or being acked, else drop it.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_pulse_len  <= '0;
      r_pause_len  <= '0;
      r_meas_valid <= 1'b0;
      r_burst_cnt  <= 16'd0;
    end else if (w_capture && (!r_meas_valid || meas_ack)) begin
      r_pulse_len  <= r_plen;
      r_pause_len  <= r_lcnt;
      r_meas_valid <= 1'b1;
      r_burst_cnt  <= r_burst_cnt + 16'd1;
    end else if (meas_ack) begin
      r_meas_valid <= 1'b0;
    end else begin
      r_meas_valid <= r_meas_valid;
    end
  end

  // Sticky flags; a set event in the same cycle as flag_clr wins.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_stuck   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_stuck_set) begin
        r_stuck <= 1'b1;
      end else if (flag_clr) begin
        r_stuck <= 1'b0;
      end else begin
        r_stuck <= r_stuck;
      end
      if (w_capture && r_meas_valid && !meas_ack) begin
        r_overrun <= 1'b1;
      end else if (flag_clr) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign pulse_len  = r_pulse_len;
  assign pause_len  = r_pause_len;
  assign meas_valid = r_meas_valid;
  assign stuck      = r_stuck;
  assign overrun    = r_overrun;
  assign burst_cnt  = r_burst_cnt;

endmodule

// File: tb/tb_iot_listen.sv
// Directed bench for iot_listen with a scoreboard of expected measurements.
module tb_iot_listen;

  logic        clk_in;
  logic        reset;
  logic        enable;
  logic        shout_in;
  logic        meas_ack;
  logic        flag_clr;
  logic [4:0]  pulse_len;
  logic [9:0]  pause_len;
  logic        meas_valid;
  logic        stuck;
  logic        overrun;
  logic [15:0] burst_cnt;

  typedef struct packed {
    logic [4:0]  p;
    logic [9:0]  q;
    logic [15:0] b;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [15:0] exp_burst;
  logic [15:0] prev_burst;

  iot_listen #(
    .SYNC_STAGES (2),
    .PULSE_W     (5),
    .PAUSE_W     (10),
    .MAX_PULSE   (20)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .enable     (enable),
    .shout_in   (shout_in),
    .meas_ack   (meas_ack),
    .flag_clr   (flag_clr),
    .pulse_len  (pulse_len),
    .pause_len  (pause_len),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .overrun    (overrun),
    .burst_cnt  (burst_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Hold shout_in at v for n clock cycles (starts and ends on a falling edge).
  task automatic seg(input logic v, input int n);
    shout_in = v;
    repeat (n) @(negedge clk_in);
  endtask

  // Same as seg, with meas_ack pulsed during the first cycle.
  task automatic seg_ack(input logic v, input int n);
    shout_in = v;
    meas_ack = 1'b1;
    @(negedge clk_in);
    meas_ack = 1'b0;
    repeat (n - 1) @(negedge clk_in);
  endtask

  task automatic push(input logic [4:0] p, input logic [9:0] q);
    exp_burst = exp_burst + 16'd1;
    sb_q.push_back('{p: p, q: q, b: exp_burst});
  endtask

  // Scoreboard monitor: every burst_cnt step is a capture and must match the queue head.
  initial begin
    prev_burst = 16'd0;
    forever begin
      @(negedge clk_in);
      if (reset === 1'b1 && burst_cnt !== prev_burst) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_capture", 32'(burst_cnt), 32'(prev_burst));
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_pulse_len", 32'(pulse_len), 32'(mon_e.p));
          chk("sb_pause_len", 32'(pause_len), 32'(mon_e.q));
          chk("sb_burst_cnt", 32'(burst_cnt), 32'(mon_e.b));
          chk("sb_meas_valid", 32'(meas_valid), 32'(1'b1));
        end
      end
      prev_burst = burst_cnt;
    end
  end

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    shout_in  = 1'b0;
    meas_ack  = 1'b0;
    flag_clr  = 1'b0;
    exp_burst = 16'd0;
    repeat (3) @(negedge clk_in);
    chk("rst_pulse_len", 32'(pulse_len), 32'd0);
    chk("rst_pause_len", 32'(pause_len), 32'd0);
    chk("rst_meas_valid", 32'(meas_valid), 32'd0);
    chk("rst_stuck", 32'(stuck), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
    reset  = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk_in);

    // Basic pairs (5,7) then (3,4), with capture latency of 3 edges.
    seg(1'b1, 5);
    seg(1'b0, 7);
    push(5'd5, 10'd7);
    shout_in = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("lat1_before", 32'(meas_valid), 32'd0);
    @(negedge clk_in);
    chk("lat1_after", 32'(meas_valid), 32'd1);
    seg_ack(1'b0, 4);
    chk("ack_clears_valid", 32'(meas_valid), 32'd0);
    push(5'd3, 10'd4);
    shout_in = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("lat2_before", 32'(meas_valid), 32'd0);
    @(negedge clk_in);
    chk("lat2_after", 32'(meas_valid), 32'd1);
    chk("burst_after_two", 32'(burst_cnt), 32'd2);

    // Free the register, go idle via enable, then (2,2) accepted and (4,6) dropped.
    seg_ack(1'b0, 5);
    enable = 1'b0;
    repeat (2) @(negedge clk_in);
    enable = 1'b1;
    seg(1'b1, 2);
    seg(1'b0, 2);
    push(5'd2, 10'd2);
    seg(1'b1, 4);
    seg(1'b0, 6);
    seg(1'b1, 3);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_keep_pulse", 32'(pulse_len), 32'd2);
    chk("ovr_keep_pause", 32'(pause_len), 32'd2);
    chk("ovr_burst", 32'(burst_cnt), 32'(exp_burst));
    flag_clr = 1'b1;
    @(negedge clk_in);
    flag_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    seg(1'b0, 5);

    // Ack in the same cycle as a new capture: (4,5) loads, no overrun.
    push(5'd4, 10'd5);
    shout_in = 1'b1;
    repeat (2) @(negedge clk_in);
    meas_ack = 1'b1;
    @(negedge clk_in);
    meas_ack = 1'b0;
    chk("same_cyc_valid", 32'(meas_valid), 32'd1);
    chk("same_cyc_overrun", 32'(overrun), 32'd0);
    chk("same_cyc_burst", 32'(burst_cnt), 32'(exp_burst));
    seg(1'b1, 3);
    seg_ack(1'b0, 4);

    // Stuck line: the (6,4) pair is captured at the rise, then 25 high cycles.
    push(5'd6, 10'd4);
    seg(1'b1, 25);
    chk("stuck_set", 32'(stuck), 32'd1);
    seg_ack(1'b0, 5);
    seg(1'b1, 6);
    chk("stuck_no_meas_valid", 32'(meas_valid), 32'd0);
    chk("stuck_no_meas_burst", 32'(burst_cnt), 32'(exp_burst));
    seg(1'b0, 3);
    push(5'd6, 10'd3);
    seg(1'b1, 3);
    chk("post_stuck_pulse", 32'(pulse_len), 32'd6);
    chk("post_stuck_pause", 32'(pause_len), 32'd3);
    chk("stuck_sticky", 32'(stuck), 32'd1);
    flag_clr = 1'b1;
    @(negedge clk_in);
    flag_clr = 1'b0;
    chk("stuck_cleared", 32'(stuck), 32'd0);

    // Long pause saturates at all-ones.
    seg_ack(1'b0, 1500);
    push(5'd4, 10'd1023);
    seg(1'b1, 3);
    chk("pause_saturated", 32'(pause_len), 32'd1023);

    // Asynchronous reset mid-pulse.
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(meas_valid), 32'd0);
    chk("async_rst_burst", 32'(burst_cnt), 32'd0);
    chk("async_rst_pulse", 32'(pulse_len), 32'd0);
    chk("async_rst_pause", 32'(pause_len), 32'd0);
    exp_burst = 16'd0;
    repeat (2) @(negedge clk_in);
    #3 reset = 1'b1;
    @(negedge clk_in);
    seg(1'b1, 4);
    seg(1'b0, 4);
    // Drop enable mid-pause; the next rise starts from IDLE.
    enable = 1'b0;
    repeat (3) @(negedge clk_in);
    enable = 1'b1;
    seg(1'b0, 3);
    seg(1'b1, 4);
    chk("reenable_no_valid", 32'(meas_valid), 32'd0);
    chk("reenable_no_burst", 32'(burst_cnt), 32'd0);
    seg(1'b0, 5);
    push(5'd4, 10'd5);
    seg(1'b1, 3);
    chk("reenable_meas_valid", 32'(meas_valid), 32'd1);
    seg_ack(1'b0, 3);
    chk("final_ack", 32'(meas_valid), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iot_listen.md
Name: iot_listen

Overview:
- Receiver for the single-wire "shout" pulse-burst line driven by the random pulse generator.
- Synchronises the incoming line and measures each high pulse width and the following low pause width, in clk_in cycles.
- Hands each (pulse, pause) pair to the host over a valid/ack holding register.
- Flags a stuck-high line and measurement overruns, and keeps a running count of accepted pulses.

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchroniser (minimum 2).
- PULSE_W, 5, width of the pulse-length counter and of pulse_len.
- PAUSE_W, 10, width of the pause-length counter and of pause_len.
- MAX_PULSE, 20, high-time count at which the line is declared stuck (must be less than 2^PULSE_W).

Ports:
- clk_in  input  1  sole clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = measure; 0 = FSM forced to IDLE and counters cleared; outputs hold.
- shout_in  input  1  shout line, asynchronous to clk_in.
- meas_ack  input  1  host consumes the current measurement.
- flag_clr  input  1  one-cycle pulse that clears stuck and overrun.
- pulse_len  output  PULSE_W  width of the last reported high pulse.
- pause_len  output  PAUSE_W  width of the low period that followed it.
- meas_valid  output  1  measurement register holds unconsumed data.
- stuck  output  1  sticky; the line was high for MAX_PULSE or more cycles.
- overrun  output  1  sticky; a measurement was dropped because the previous one was not acked.
- burst_cnt  output  16  count of accepted measurements; wraps modulo 2^16.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs and counters are 0.
  - Synchroniser flops are 0.
  - FSM is in IDLE.
- Input path:
  - shout_s is the last synchroniser stage; shout_d is shout_s delayed one cycle.
  - rise = shout_s & ~shout_d; fall = ~shout_s & shout_d.
- FSM states: IDLE, HIGH, LOW, STUCK.
  - IDLE: on rise -> HIGH with hcnt=1. The pause before the first pulse is never reported.
  - HIGH: hcnt increments each cycle shout_s=1.
    - If hcnt reaches MAX_PULSE -> STUCK; stuck<=1.
    - On fall -> LOW; the pulse width is latched into plen and lcnt=1.
  - LOW: lcnt increments each cycle shout_s=0, saturating at 2^PAUSE_W-1.
    - On rise: capture (plen, lcnt) -> HIGH with hcnt=1.
  - STUCK: on fall -> IDLE; no measurement is produced. stuck remains set until flag_clr.
- Capture / handshake:
  - If meas_valid=0, or meas_ack=1 in the same cycle: load pulse_len/pause_len, set meas_valid=1, increment burst_cnt.
  - If meas_valid=1 and meas_ack=0: keep the old data, drop the new pair, set overrun=1, leave burst_cnt unchanged.
  - meas_ack with no capture in the same cycle: meas_valid<=0 next cycle. meas_ack while meas_valid=0 is ignored.
- Latency: pulse_len/pause_len/meas_valid update at the clk_in edge that detects rise. With SYNC_STAGES=2 they are visible 3 edges after shout_in rises at the synchroniser input.
- flag_clr: clears stuck and overrun. If a set event occurs in the same cycle, set wins.
- enable=0:
  - FSM goes to IDLE; hcnt/lcnt are cleared.
  - The handshake register, flags and burst_cnt hold. meas_ack and flag_clr still act.
- Widths:
  - hcnt cannot exceed MAX_PULSE.
  - lcnt saturates; a saturated value is reported as all-ones.
  - burst_cnt wraps 0xFFFF -> 0x0000.
- A 1-cycle high or 1-cycle low at shout_s is measured as width 1; there is no glitch filter.

Decomposition:
- Shared package iot_shout_pkg holds:
  - FSM state enum (IDLE, HIGH, LOW, STUCK).
  - Default values for PULSE_W, PAUSE_W and MAX_PULSE, so the generator and the listener agree on widths.
- One sub-module: iot_sync, an SYNC_STAGES-deep flop synchroniser with async active-low reset, reusable for other asynchronous inputs.

Test Plan:
- Reset, then shout_in high 5 cycles, low 7, high 3, low 4, high -> two measurements:
  - (5,7) with burst_cnt=1.
  - (3,4) with burst_cnt=2, accepted only if the first was acked.
  - meas_valid rises 3 cycles after each shout_in rise.
- No ack, then pulses (2,2) followed by (4,6) -> pulse_len=2, pause_len=2 retained; overrun=1; burst_cnt=1. flag_clr clears overrun.
- meas_ack asserted in the same cycle as a new capture -> new data loads, meas_valid stays 1, burst_cnt increments, overrun stays 0.
- shout_in held high 25 cycles with MAX_PULSE=20 -> stuck=1; no measurement on the following fall or rise. Next clean pulse (6,3) is reported normally.
- Low period of 1500 cycles with PAUSE_W=10 -> pause_len=1023.
- Reset deasserted asynchronously mid-pulse, and enable dropped mid-pause -> outputs 0 after reset. Neither event produces a spurious measurement; the first pulse after re-enable is measured only from IDLE.
